led_pwm_fader: RTL and testbench
================================

LED_PWM_FADER -- requirements
Module: led_pwm_fader

Interface
REQ-001 SHALL have parameter PWM_BITS, default 4, brightness resolution; levels 0..2^PWM_BITS-1 (MAX).
REQ-002 SHALL have parameter STEP_FRAMES, default 4, PWM frames per brightness step; legal range >= 1.
REQ-003 SHALL have port sys_clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port led_in  input  4  on/off pattern from the upstream flow-LED stage, same clock domain.
REQ-006 SHALL have port led_out  output  4  PWM-faded drive to the LED pins, registered.
REQ-007 SHALL have port fade_busy  output  1  ramp-in-progress flag, present only when LED_FADE_STATUS_EN is defined (REQ-024).

Function
REQ-008 SHALL register led_in into led_q every cycle; all level updates use led_q.
REQ-009 SHALL run a free-running PWM counter pwm_cnt, PWM_BITS wide, incrementing every cycle, wrapping MAX->0; one wrap = one frame of 2^PWM_BITS cycles.
REQ-010 SHALL run a frame counter step_cnt, 0..STEP_FRAMES-1, advancing when pwm_cnt==MAX and wrapping to 0 after STEP_FRAMES-1.
REQ-011 SHALL generate a one-cycle step tick when pwm_cnt==MAX and step_cnt==STEP_FRAMES-1; tick period = STEP_FRAMES*2^PWM_BITS cycles.
REQ-012 SHALL hold one PWM_BITS-wide level register per channel i (0..3).
REQ-013 On a step tick, channel i SHALL increment level if led_q[i]==1 and level<MAX, decrement if led_q[i]==0 and level>0, else hold.
REQ-014 Levels SHALL saturate at 0 and MAX; no wrap-around.
REQ-015 A led_in change mid-ramp SHALL reverse direction from the current level at the next tick; no jump, no restart.
REQ-016 Between ticks, levels SHALL be unchanged regardless of led_in activity; pulses shorter than one tick period affect only the ticks they overlap.
REQ-017 led_out[i] SHALL be registered as 1 when level==MAX or pwm_cnt<level, else 0; level 0 gives constant 0, MAX gives constant 1, level L gives L high cycles per frame.
REQ-018 led_out SHALL lag pwm_cnt/level by exactly one cycle.
REQ-019 The four channels SHALL be independent and share pwm_cnt, step_cnt and the tick.

Reset
REQ-020 On sys_rst_n low, SHALL immediately clear led_q, pwm_cnt, step_cnt, all levels, led_out (4'b0000) and fade_busy (0).
REQ-021 Reset asserted mid-ramp SHALL discard progress; after release all channels restart from level 0 and pwm_cnt 0.
REQ-022 First tick after release SHALL occur at cycle STEP_FRAMES*2^PWM_BITS (64 with defaults).

Configuration
REQ-023 Macro LED_FADE_STATUS_EN SHALL select the status feature.
REQ-024 With LED_FADE_STATUS_EN defined, fade_busy SHALL be registered high while any channel's level differs from its target (MAX if led_q[i]==1, 0 otherwise), low otherwise.
REQ-025 Without LED_FADE_STATUS_EN, port fade_busy and its logic SHALL be absent; all other behaviour identical.

Verification (defaults PWM_BITS=4, STEP_FRAMES=4: frame 16 cycles, tick 64 cycles, full ramp 960 cycles)
REQ-026 Reset held, led_in=4'b1111 -> led_out=4'b0000, fade_busy=0 throughout.
REQ-027 Release reset, led_in=4'b0001 held -> after first tick led_out[0] high 1 of 16 cycles; after 15th tick (cycle 960) led_out[0] constant 1; led_out[3:1]=0 throughout.
REQ-028 Continue holding 4'b0001 for 5 more ticks -> led_out[0] stays constant 1 (saturation), fade_busy=0 (macro on).
REQ-029 Ramp channel 0 to level 8, then led_in=4'b0000 -> next tick level 7 (7 high cycles/frame), reaching constant 0 after 7 more ticks; fade_busy high during, low after.
REQ-030 Assert sys_rst_n low mid-ramp at level 5 -> led_out=4'b0000 same cycle without clock; after release, channel restarts at level 0, first increment at cycle 64.
REQ-031 led_in=4'b1010 -> channels 1 and 3 ramp identically and simultaneously, channels 0 and 2 stay 0; build without macro compiles with no fade_busy port and identical led_out.

Source files
------------

// File: rtl/led_pwm_fader.sv
// Four-channel LED fader: each channel's brightness ramps one level per step tick toward
// full-on or off, and a shared PWM counter turns that level into a duty cycle.
// Define LED_FADE_STATUS_EN to add the fade_busy ramp-in-progress output.
module led_pwm_fader #(
  parameter int PWM_BITS    = 4,
  parameter int STEP_FRAMES = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [3:0] led_in,
  output logic [3:0] led_out
`ifdef LED_FADE_STATUS_EN
  ,
  output logic       fade_busy
`endif
);

  localparam int STEP_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam logic [PWM_BITS-1:0] MAX_LEVEL = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] MIN_LEVEL = {PWM_BITS{1'b0}};
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_FRAMES - 1);

  logic [3:0]                  led_q;
  logic [PWM_BITS-1:0]         pwm_cnt;
  logic [STEP_W-1:0]           step_cnt;
  logic [3:0][PWM_BITS-1:0]    level;
  logic [3:0][PWM_BITS-1:0]    level_nxt;
  logic                        frame_end;
  logic                        step_tick;

  // Level each channel is heading toward, given its requested on/off state.
  function automatic logic [PWM_BITS-1:0] level_target(input logic on);
    return on ? MAX_LEVEL : MIN_LEVEL;
  endfunction

  assign frame_end = (pwm_cnt == MAX_LEVEL);
  assign step_tick = frame_end && (step_cnt == STEP_LAST);

  // Next brightness per channel: one saturating step toward the target on a tick.
  always_comb begin
    level_nxt = level;
    for (int i = 0; i < 4; i++) begin
      if (step_tick && led_q[i] && (level[i] != MAX_LEVEL)) begin
        level_nxt[i] = level[i] + PWM_BITS'(1);
      end else if (step_tick && !led_q[i] && (level[i] != MIN_LEVEL)) begin
        level_nxt[i] = level[i] - PWM_BITS'(1);
      end else begin
        level_nxt[i] = level[i];
      end
    end
  end

  // Input capture, PWM/frame counters and channel levels.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      led_q    <= 4'b0000;
      pwm_cnt  <= MIN_LEVEL;
      step_cnt <= {STEP_W{1'b0}};
      level    <= '0;
    end else begin
      led_q   <= led_in;
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (frame_end) begin
        step_cnt <= (step_cnt == STEP_LAST) ? {STEP_W{1'b0}} : step_cnt + STEP_W'(1);
      end else begin
        step_cnt <= step_cnt;
      end
      level <= level_nxt;
    end
  end

  // PWM comparator; MAX is forced fully on so the top level has no dark cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      led_out <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        led_out[i] <= (level[i] == MAX_LEVEL) || (pwm_cnt < level[i]);
      end
    end
  end

`ifdef LED_FADE_STATUS_EN
  logic busy_nxt;

  // Busy while any channel has not yet reached its target level.
  always_comb begin
    busy_nxt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (level[i] != level_target(led_q[i])) begin
        busy_nxt = 1'b1;
      end else begin
        busy_nxt = busy_nxt;
      end
    end
  end

  // Registered status flag.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      fade_busy <= 1'b0;
    end else begin
      fade_busy <= busy_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_led_pwm_fader.sv
// Self-checking bench for led_pwm_fader: directed ramp/saturation/reset scenarios plus
// random led_in segments, compared every cycle against a cycle-count based model.
module tb_led_pwm_fader;

  localparam int PWM_BITS    = 4;
  localparam int STEP_FRAMES = 4;
  localparam int MAXL        = (1 << PWM_BITS) - 1;
  localparam int FRAME       = 1 << PWM_BITS;
  localparam int TICK        = STEP_FRAMES * FRAME;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [3:0] led_in    = 4'b0000;
  logic [3:0] led_out;
  logic       fade_busy;

  int checks   = 0;
  int failures = 0;

  // Model: cycles since reset release, per-channel level, captured input, expected outputs.
  int         m_cyc;
  int         m_lev [4];
  logic [3:0] m_q;
  logic [3:0] m_out;
  logic       m_busy;

  led_pwm_fader #(.PWM_BITS(PWM_BITS), .STEP_FRAMES(STEP_FRAMES)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .led_in    (led_in),
    .led_out   (led_out)
`ifdef LED_FADE_STATUS_EN
    ,
    .fade_busy (fade_busy)
`endif
  );

`ifndef LED_FADE_STATUS_EN
  assign fade_busy = 1'b0;
`endif

  always #5 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cyc  = 0;
    for (int i = 0; i < 4; i++) m_lev[i] = 0;
    m_q    = 4'b0000;
    m_out  = 4'b0000;
    m_busy = 1'b0;
  endtask

  // Abstract behaviour: brightness steps once every TICK cycles; duty is position within frame.
  task automatic model_edge();
    int         ph;
    bit         tick;
    logic [3:0] nout;
    logic       nbusy;
    ph    = m_cyc % FRAME;
    tick  = ((m_cyc % TICK) == TICK - 1);
    nbusy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nout[i] = (m_lev[i] == MAXL) || (ph < m_lev[i]);
      if (m_lev[i] != (m_q[i] ? MAXL : 0)) nbusy = 1'b1;
    end
    if (tick) begin
      for (int i = 0; i < 4; i++) begin
        if (m_q[i] && m_lev[i] < MAXL) m_lev[i] = m_lev[i] + 1;
        else if (!m_q[i] && m_lev[i] > 0) m_lev[i] = m_lev[i] - 1;
      end
    end
    m_out  = nout;
    m_busy = nbusy;
    m_q    = led_in;
    m_cyc  = m_cyc + 1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge sys_clk);
      if (sys_rst_n) model_edge();
      else model_reset();
      #1;
      check_eq("led_out", {28'd0, led_out}, {28'd0, m_out});
`ifdef LED_FADE_STATUS_EN
      check_eq("fade_busy", {31'd0, fade_busy}, {31'd0, m_busy});
`endif
    end
  endtask

  // Count high cycles of one channel across a full frame and compare with the model level.
  task automatic duty(input int ch);
    int cnt;
    int exp;
    for (int g = 0; g < FRAME && (m_cyc % FRAME) != 1; g++) run(1);
    exp = (m_lev[ch] == MAXL) ? FRAME : m_lev[ch];
    cnt = led_out[ch];
    for (int k = 0; k < FRAME - 1; k++) begin
      run(1);
      cnt += led_out[ch];
    end
    check_eq("duty", 32'(cnt), 32'(exp));
  endtask

  // Assert reset between clock edges; outputs must clear without a clock edge.
  task automatic async_reset();
    #3;
    sys_rst_n = 1'b0;
    #1;
    check_eq("async_rst_out", {28'd0, led_out}, 32'd0);
    check_eq("async_rst_busy", {31'd0, fade_busy}, 32'd0);
    model_reset();
  endtask

  task automatic release_reset();
    sys_rst_n = 1'b1;
  endtask

  task automatic run_until_level(input int ch, input int lvl);
    for (int g = 0; g < 20 * TICK && m_lev[ch] != lvl; g++) run(1);
    check_eq("reach_level", 32'(m_lev[ch]), 32'(lvl));
  endtask

  initial begin
    model_reset();
    // Reset held with all inputs requesting on.
    led_in = 4'b1111;
    run(6);
    check_eq("reset_hold", {28'd0, led_out}, 32'd0);

    // Single-channel ramp: first step at cycle 64, full at cycle 960, then saturation.
    led_in = 4'b0001;
    release_reset();
    run(TICK);
    duty(0);
    check_eq("first_level", 32'(m_lev[0]), 32'd1);
    run(15 * TICK - m_cyc + 1);
    duty(0);
    run(5 * TICK);
    duty(0);
    check_eq("sat_level", 32'(m_lev[0]), 32'(MAXL));

    // Ramp to 8, then fade down through 7 to 0.
    async_reset();
    run(2);
    release_reset();
    run_until_level(0, 8);
    led_in = 4'b0000;
    run(TICK);
    duty(0);
    run(7 * TICK + 20);
    duty(0);

    // Reset mid-ramp at level 5 discards progress.
    led_in = 4'b0001;
    async_reset();
    run(2);
    release_reset();
    run_until_level(0, 5);
    run(10);
    async_reset();
    run(3);
    release_reset();
    run(TICK + 6);
    duty(0);

    // Two alternating channels ramp in lockstep.
    led_in = 4'b1010;
    async_reset();
    run(2);
    release_reset();
    run(1000);
    duty(1);
    duty(3);

    // Random led_in segments, including short pulses and occasional resets.
    for (int s = 0; s < 40; s++) begin
      led_in = 4'($urandom_range(0, 15));
      run($urandom_range(1, 150));
      if ($urandom_range(0, 9) == 0) begin
        async_reset();
        run($urandom_range(1, 4));
        release_reset();
      end
    end
    duty($urandom_range(0, 3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
